// File: rtl/pipe_hazard_ctrl_if.sv
// Datapath <-> hazard controller bundle: decode-stage fields and pipeline status in,
// register enables, flushes and forwarding selects out.
interface pipe_hazard_ctrl_if #(
  parameter int unsigned RF_ADDRESS = 5,
  parameter int unsigned CNT_W      = 16
);
  logic                  id_valid;
  logic [RF_ADDRESS-1:0] id_rs1;
  logic [RF_ADDRESS-1:0] id_rs2;
  logic                  id_use_rs1;
  logic                  id_use_rs2;
  logic [RF_ADDRESS-1:0] id_rd;
  logic                  id_regwrite;
  logic                  id_memread;
  logic                  id_memop;
  logic                  ex_redirect;
  logic                  mem_ready;

  logic                  pc_en;
  logic                  ifid_en;
  logic                  exmem_en;
  logic                  memwb_en;
  logic                  ifid_flush;
  logic                  idex_flush;
  logic [1:0]            fwd_a;
  logic [1:0]            fwd_b;
  logic [1:0]            ctrl_state;
  logic [CNT_W-1:0]      stall_cycles;

  // Datapath side
  modport master (
    output id_valid, id_rs1, id_rs2, id_use_rs1, id_use_rs2, id_rd,
           id_regwrite, id_memread, id_memop, ex_redirect, mem_ready,
    input  pc_en, ifid_en, exmem_en, memwb_en, ifid_flush, idex_flush,
           fwd_a, fwd_b, ctrl_state, stall_cycles
  );

  // Controller side
  modport slave (
    input  id_valid, id_rs1, id_rs2, id_use_rs1, id_use_rs2, id_rd,
           id_regwrite, id_memread, id_memop, ex_redirect, mem_ready,
    output pc_en, ifid_en, exmem_en, memwb_en, ifid_flush, idex_flush,
           fwd_a, fwd_b, ctrl_state, stall_cycles
  );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// Five-stage pipeline sequencing controller: shadows EX/MEM/WB metadata and derives
// stage enables, flushes, load-use stalls, redirect squashes, memory-wait freezes and
// EX operand forwarding selects.
module pipe_hazard_ctrl #(
  parameter int unsigned RF_ADDRESS = 5,
  parameter int unsigned CNT_W      = 16
) (
  input logic              clk,
  input logic              reset,
  pipe_hazard_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    StRun     = 2'd0,
    StLdStall = 2'd1,
    StFlush   = 2'd2,
    StMwait   = 2'd3
  } action_e;

  action_e state_q, state_d;

  logic [CNT_W-1:0] stall_q;

  // EX shadow
  logic                  ex_v_q, ex_rw_q, ex_mr_q, ex_mo_q, ex_use1_q, ex_use2_q;
  logic [RF_ADDRESS-1:0] ex_rd_q, ex_rs1_q, ex_rs2_q;
  // MEM shadow
  logic                  mem_v_q, mem_rw_q, mem_mo_q;
  logic [RF_ADDRESS-1:0] mem_rd_q;
  // WB shadow
  logic                  wb_v_q, wb_rw_q;
  logic [RF_ADDRESS-1:0] wb_rd_q;

  logic mwait, redir, lduse;
  logic pc_en, ifid_en, exmem_en, memwb_en, ifid_flush, idex_flush;
  logic [1:0] fwd_a, fwd_b;

  // Hazard conditions from shadow state and decode fields
  always_comb begin
    mwait = mem_v_q & mem_mo_q & ~bus.mem_ready;
    redir = ex_v_q & bus.ex_redirect;
    lduse = ex_v_q & ex_mr_q & (ex_rd_q != '0) & bus.id_valid &
            ((bus.id_use_rs1 & (bus.id_rs1 == ex_rd_q)) |
             (bus.id_use_rs2 & (bus.id_rs2 == ex_rd_q)));
  end

  // Action select: mwait > redir > lduse > run
  always_comb begin
    state_d = StRun;
    if (mwait) begin
      state_d = StMwait;
    end else if (redir) begin
      state_d = StFlush;
    end else if (lduse) begin
      state_d = StLdStall;
    end
  end

  // Register enables and flushes for the selected action; forced safe values in reset
  always_comb begin
    pc_en      = 1'b1;
    ifid_en    = 1'b1;
    exmem_en   = 1'b1;
    memwb_en   = 1'b1;
    ifid_flush = 1'b0;
    idex_flush = 1'b0;
    if (!reset) begin
      pc_en      = 1'b0;
      ifid_en    = 1'b0;
      exmem_en   = 1'b0;
      memwb_en   = 1'b0;
      ifid_flush = 1'b1;
      idex_flush = 1'b1;
    end else begin
      unique case (state_d)
        StMwait: begin
          pc_en    = 1'b0;
          ifid_en  = 1'b0;
          exmem_en = 1'b0;
          memwb_en = 1'b0;
        end
        StFlush: begin
          ifid_flush = 1'b1;
          idex_flush = 1'b1;
        end
        StLdStall: begin
          pc_en      = 1'b0;
          ifid_en    = 1'b0;
          idex_flush = 1'b1;
        end
        StRun: ;
      endcase
    end
  end

  // Forwarding selects: youngest producer (EX/MEM) wins, x0 never forwarded
  always_comb begin
    fwd_a = 2'b00;
    fwd_b = 2'b00;
    if (reset) begin
      if (mem_v_q & mem_rw_q & (mem_rd_q != '0) & (mem_rd_q == ex_rs1_q) & ex_use1_q) begin
        fwd_a = 2'b10;
      end else if (wb_v_q & wb_rw_q & (wb_rd_q != '0) & (wb_rd_q == ex_rs1_q) & ex_use1_q) begin
        fwd_a = 2'b01;
      end
      if (mem_v_q & mem_rw_q & (mem_rd_q != '0) & (mem_rd_q == ex_rs2_q) & ex_use2_q) begin
        fwd_b = 2'b10;
      end else if (wb_v_q & wb_rw_q & (wb_rd_q != '0) & (wb_rd_q == ex_rs2_q) & ex_use2_q) begin
        fwd_b = 2'b01;
      end
    end
  end

  // Shadow pipeline: hold on mwait, otherwise advance with ID or a bubble entering EX
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ex_v_q    <= 1'b0;
      ex_rw_q   <= 1'b0;
      ex_mr_q   <= 1'b0;
      ex_mo_q   <= 1'b0;
      ex_use1_q <= 1'b0;
      ex_use2_q <= 1'b0;
      ex_rd_q   <= '0;
      ex_rs1_q  <= '0;
      ex_rs2_q  <= '0;
      mem_v_q   <= 1'b0;
      mem_rw_q  <= 1'b0;
      mem_mo_q  <= 1'b0;
      mem_rd_q  <= '0;
      wb_v_q    <= 1'b0;
      wb_rw_q   <= 1'b0;
      wb_rd_q   <= '0;
    end else if (state_d != StMwait) begin
      wb_v_q   <= mem_v_q;
      wb_rw_q  <= mem_rw_q;
      wb_rd_q  <= mem_rd_q;
      mem_v_q  <= ex_v_q;
      mem_rw_q <= ex_rw_q;
      mem_mo_q <= ex_mo_q;
      mem_rd_q <= ex_rd_q;
      if (state_d == StRun) begin
        ex_v_q    <= bus.id_valid;
        ex_rw_q   <= bus.id_regwrite;
        ex_mr_q   <= bus.id_memread;
        ex_mo_q   <= bus.id_memop;
        ex_use1_q <= bus.id_use_rs1;
        ex_use2_q <= bus.id_use_rs2;
        ex_rd_q   <= bus.id_rd;
        ex_rs1_q  <= bus.id_rs1;
        ex_rs2_q  <= bus.id_rs2;
      end else begin
        // Bubble is fully cleared so it can never trigger forwarding
        ex_v_q    <= 1'b0;
        ex_rw_q   <= 1'b0;
        ex_mr_q   <= 1'b0;
        ex_mo_q   <= 1'b0;
        ex_use1_q <= 1'b0;
        ex_use2_q <= 1'b0;
        ex_rd_q   <= '0;
        ex_rs1_q  <= '0;
        ex_rs2_q  <= '0;
      end
    end
  end

  // Last applied action and saturating count of cycles with the PC frozen
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= StRun;
      stall_q <= '0;
    end else begin
      state_q <= state_d;
      if (((state_d == StMwait) || (state_d == StLdStall)) && (stall_q != '1)) begin
        stall_q <= stall_q + CNT_W'(1);
      end
    end
  end

  assign bus.pc_en        = pc_en;
  assign bus.ifid_en      = ifid_en;
  assign bus.exmem_en     = exmem_en;
  assign bus.memwb_en     = memwb_en;
  assign bus.ifid_flush   = ifid_flush;
  assign bus.idex_flush   = idex_flush;
  assign bus.fwd_a        = fwd_a;
  assign bus.fwd_b        = fwd_b;
  assign bus.ctrl_state   = state_q;
  assign bus.stall_cycles = stall_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Self-checking bench for pipe_hazard_ctrl: directed scenarios plus random stimulus,
// compared each cycle against a queue-of-instructions reference model.
module tb_pipe_hazard_ctrl;

  logic clk;
  logic reset;

  pipe_hazard_ctrl_if #(.RF_ADDRESS(5), .CNT_W(16)) bus ();
  pipe_hazard_ctrl_if #(.RF_ADDRESS(5), .CNT_W(4))  bus_sat ();

  pipe_hazard_ctrl #(.RF_ADDRESS(5), .CNT_W(16)) u_dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  pipe_hazard_ctrl #(.RF_ADDRESS(5), .CNT_W(4)) u_dut_sat (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_sat.slave)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    bit v;
    int rs1, rs2, rd;
    bit u1, u2, rw, mr, mo;
    bit redirect, ready;
  } stim_t;

  // Instruction record held in the model's pipeline: index 0 = EX, 1 = MEM, 2 = WB
  typedef struct {
    bit v;
    int rd, rs1, rs2;
    bit rw, mr, mo, u1, u2;
  } ins_t;

  ins_t stg[3];
  int   m_state;
  int   m_cnt;
  int   m_cnt_sat;
  int   n_chk;
  int   n_pass;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      $display("FAIL %s at %0t: got %0d expected %0d", tag, $time, got, exp);
    end else begin
      n_pass++;
    end
  endtask

  function automatic ins_t bubble();
    ins_t b;
    b.v = 0; b.rd = 0; b.rs1 = 0; b.rs2 = 0;
    b.rw = 0; b.mr = 0; b.mo = 0; b.u1 = 0; b.u2 = 0;
    return b;
  endfunction

  task automatic model_clear();
    for (int i = 0; i < 3; i++) stg[i] = bubble();
    m_state   = 0;
    m_cnt     = 0;
    m_cnt_sat = 0;
  endtask

  // Nearest older writer of src among MEM then WB decides the bypass source
  function automatic int fwd_sel(input int src, input bit use_it);
    if (!use_it) return 0;
    for (int s = 1; s <= 2; s++) begin
      if (stg[s].v && stg[s].rw && stg[s].rd != 0 && stg[s].rd == src) return (s == 1) ? 2 : 1;
    end
    return 0;
  endfunction

  function automatic stim_t mk(input bit v, input int rs1, input int rs2, input bit u1,
                               input bit u2, input int rd, input bit rw, input bit mr,
                               input bit mo, input bit redirect, input bit ready);
    stim_t s;
    s.v = v; s.rs1 = rs1; s.rs2 = rs2; s.u1 = u1; s.u2 = u2; s.rd = rd;
    s.rw = rw; s.mr = mr; s.mo = mo; s.redirect = redirect; s.ready = ready;
    return s;
  endfunction

  function automatic stim_t rand_stim();
    stim_t s;
    s.v        = ($urandom % 4) != 0;
    s.rs1      = $urandom_range(0, 3);
    s.rs2      = $urandom_range(0, 3);
    s.rd       = $urandom_range(0, 3);
    s.u1       = s.v && $urandom_range(0, 1) == 1;
    s.u2       = s.v && $urandom_range(0, 1) == 1;
    s.rw       = $urandom_range(0, 1) == 1;
    s.mr       = ($urandom % 3) == 0;
    s.mo       = s.mr || (($urandom % 4) == 0);
    s.redirect = ($urandom % 5) == 0;
    s.ready    = ($urandom % 3) != 0;
    return s;
  endfunction

  task automatic apply(input stim_t s);
    bus.id_valid        = s.v;
    bus.id_rs1          = 5'(s.rs1);
    bus.id_rs2          = 5'(s.rs2);
    bus.id_use_rs1      = s.u1;
    bus.id_use_rs2      = s.u2;
    bus.id_rd           = 5'(s.rd);
    bus.id_regwrite     = s.rw;
    bus.id_memread      = s.mr;
    bus.id_memop        = s.mo;
    bus.ex_redirect     = s.redirect;
    bus.mem_ready       = s.ready;
    bus_sat.id_valid    = s.v;
    bus_sat.id_rs1      = 5'(s.rs1);
    bus_sat.id_rs2      = 5'(s.rs2);
    bus_sat.id_use_rs1  = s.u1;
    bus_sat.id_use_rs2  = s.u2;
    bus_sat.id_rd       = 5'(s.rd);
    bus_sat.id_regwrite = s.rw;
    bus_sat.id_memread  = s.mr;
    bus_sat.id_memop    = s.mo;
    bus_sat.ex_redirect = s.redirect;
    bus_sat.mem_ready   = s.ready;
  endtask

  // One clock: drive at negedge, check combinational and registered outputs, then advance model
  task automatic cycle(input stim_t s, input bit rst_v);
    bit mw, rd_hit, lu, frozen;
    int act;
    @(negedge clk);
    reset = rst_v;
    apply(s);
    if (!rst_v) model_clear();
    #1;
    mw     = stg[1].v && stg[1].mo && !s.ready;
    rd_hit = stg[0].v && s.redirect;
    lu     = stg[0].v && stg[0].mr && stg[0].rd != 0 && s.v &&
             ((s.u1 && s.rs1 == stg[0].rd) || (s.u2 && s.rs2 == stg[0].rd));
    act    = mw ? 3 : rd_hit ? 2 : lu ? 1 : 0;
    frozen = (act == 1) || (act == 3);
    if (!rst_v) begin
      check_eq("pc_en",      32'(bus.pc_en),      0);
      check_eq("ifid_en",    32'(bus.ifid_en),    0);
      check_eq("exmem_en",   32'(bus.exmem_en),   0);
      check_eq("memwb_en",   32'(bus.memwb_en),   0);
      check_eq("ifid_flush", 32'(bus.ifid_flush), 1);
      check_eq("idex_flush", 32'(bus.idex_flush), 1);
      check_eq("fwd_a",      32'(bus.fwd_a),      0);
      check_eq("fwd_b",      32'(bus.fwd_b),      0);
    end else begin
      check_eq("pc_en",      32'(bus.pc_en),      32'(!frozen));
      check_eq("ifid_en",    32'(bus.ifid_en),    32'(!frozen));
      check_eq("exmem_en",   32'(bus.exmem_en),   32'(act != 3));
      check_eq("memwb_en",   32'(bus.memwb_en),   32'(act != 3));
      check_eq("ifid_flush", 32'(bus.ifid_flush), 32'(act == 2));
      check_eq("idex_flush", 32'(bus.idex_flush), 32'(act == 2 || act == 1));
      check_eq("fwd_a",      32'(bus.fwd_a),      32'(fwd_sel(stg[0].rs1, stg[0].u1)));
      check_eq("fwd_b",      32'(bus.fwd_b),      32'(fwd_sel(stg[0].rs2, stg[0].u2)));
    end
    check_eq("ctrl_state",   32'(bus.ctrl_state),       32'(m_state));
    check_eq("stall_cycles", 32'(bus.stall_cycles),     32'(m_cnt));
    check_eq("stall_sat",    32'(bus_sat.stall_cycles), 32'(m_cnt_sat));
    @(posedge clk);
    if (rst_v) begin
      if (act != 3) begin
        ins_t n;
        stg[2] = stg[1];
        stg[1] = stg[0];
        n = bubble();
        if (act == 0) begin
          n.v = s.v; n.rd = s.rd; n.rs1 = s.rs1; n.rs2 = s.rs2;
          n.rw = s.rw; n.mr = s.mr; n.mo = s.mo; n.u1 = s.u1; n.u2 = s.u2;
        end
        stg[0] = n;
      end
      m_state = act;
      if (frozen) begin
        if (m_cnt < 65535) m_cnt++;
        if (m_cnt_sat < 15) m_cnt_sat++;
      end
    end
  endtask

  stim_t nop;

  initial begin
    n_chk  = 0;
    n_pass = 0;
    reset  = 1'b0;
    model_clear();
    nop = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    apply(nop);

    // Reset held with random inputs
    for (int i = 0; i < 3; i++) cycle(rand_stim(), 1'b0);

    // Load-use: lw x5, then add x6,x5,x2 held in ID across the stall
    cycle(mk(1, 1, 0, 1, 0, 5, 1, 1, 1, 0, 1), 1'b1);
    cycle(mk(1, 5, 2, 1, 1, 6, 1, 0, 0, 0, 1), 1'b1);
    cycle(mk(1, 5, 2, 1, 1, 6, 1, 0, 0, 0, 1), 1'b1);
    cycle(nop, 1'b1);
    cycle(nop, 1'b1);

    // Forward priority: two writers of x3, then a reader of rs2=3; repeat with x0
    for (int r = 0; r < 2; r++) begin
      int d;
      d = (r == 0) ? 3 : 0;
      cycle(mk(1, 1, 2, 1, 1, d, 1, 0, 0, 0, 1), 1'b1);
      cycle(mk(1, 1, 2, 1, 1, d, 1, 0, 0, 0, 1), 1'b1);
      cycle(mk(1, 1, d, 0, 1, 7, 1, 0, 0, 0, 1), 1'b1);
      cycle(nop, 1'b1);
      cycle(nop, 1'b1);
    end

    // Redirect coinciding with a load-use hazard
    cycle(mk(1, 1, 0, 1, 0, 5, 1, 1, 1, 0, 1), 1'b1);
    cycle(mk(1, 5, 0, 1, 0, 6, 1, 0, 0, 1, 1), 1'b1);
    cycle(nop, 1'b1);

    // Store reaches MEM, then a long memory wait to saturate the narrow counter
    cycle(mk(1, 1, 2, 1, 1, 0, 0, 0, 1, 0, 1), 1'b1);
    cycle(nop, 1'b1);
    for (int i = 0; i < 20; i++) cycle(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), 1'b1);
    cycle(nop, 1'b1);
    cycle(nop, 1'b1);

    // Random traffic with occasional asynchronous reset pulses
    for (int i = 0; i < 1500; i++) cycle(rand_stim(), ($urandom % 150) != 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
